param_register_stack: RTL
=========================

Name: param_register_stack

Overview:
- Parametrised successor to the processor's operand stack. Top and second entries are always visible combinationally on a/b.
- Adds configurable width and depth, an occupancy counter, and full/empty status.
- Adds sticky overflow/underflow/error detection, plus DUP and OVER operations.
- Sits between the ALU/IO datapath and the control unit. Opcodes 0-5 keep the existing stack semantics.

Parameters:
- WIDTH, 16, bit width of each entry and of w/a/b
- DEPTH, 64, number of entries; must be >= 4
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter

Ports:
- CLK  in  1  clock; all state updates on negedge CLK, matching the datapath stack timing
- reset  in  1  synchronous, active-high; sampled on negedge CLK
- stackOP  in  3  operation code (see Behaviour)
- w  in  WIDTH  write data for push / pop-and-replace
- clr_err  in  1  clears the sticky error flags on the next negedge
- a  out  WIDTH  entry 0 (top of stack)
- b  out  WIDTH  entry 1
- depth  out  CNT_W  current number of valid entries
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- overflow  out  1  sticky: a push-type op was attempted while full
- underflow  out  1  sticky: an op needed more valid entries than present

Behaviour:
- Storage is a shift-register array stack[0..DEPTH-1]. a = stack[0] and b = stack[1] are combinational from registers.
- Entries at index >= depth always hold 0; vacated slots are written 0.
- Reset (negedge CLK with reset=1): all entries = 0, depth = 0, overflow = underflow = 0.
  - Reset overrides any stackOP and clr_err in the same cycle.
- Reset-state outputs: a = b = 0, depth = 0, empty = 1, full = 0.
- Opcodes; each takes effect at the negedge it is sampled, with no latency beyond one edge:
  - 0 NOP: no change.
  - 1 PUSH: shift down one; stack[0] = w; depth+1. Requires depth < DEPTH.
  - 2 POP_REPLACE: stack[0] = w; entries 2.. shift up one; last slot = 0; depth-1. Requires depth >= 2.
  - 3 POP: shift up one; last slot = 0; depth-1. Requires depth >= 1.
  - 4 POP2: shift up two; last two slots = 0; depth-2. Requires depth >= 2.
  - 5 SWAP: exchange stack[0] and stack[1]; depth unchanged. Requires depth >= 2.
  - 6 DUP: push a copy of stack[0]; depth+1. Requires 1 <= depth < DEPTH.
  - 7 OVER: push a copy of stack[1]; depth+1. Requires 2 <= depth < DEPTH.
- Requirement violated: the op is suppressed entirely; stack and depth are unchanged.
  - overflow is set if the depth < DEPTH condition failed.
  - Otherwise underflow is set.
  - For DUP/OVER on an empty stack, underflow has priority over overflow.
- Sticky flags hold until reset, or until clr_err=1.
  - If clr_err and a new violation occur on the same edge, the new violation wins: the flag ends at 1.
- depth never wraps; it is saturated by the suppression rule above.
- full and empty are combinational from depth.

Optional Feature:
- Macro STACK_PEEK_EN.
- Defined: adds input peek_idx [$clog2(DEPTH)-1:0] and output peek_data [WIDTH-1:0] = stack[peek_idx], combinational. The peek read does not alter state.
- Undefined: neither port exists; the array has no random read mux.

Decomposition:
- Shared package stack_pkg holds:
  - opcode localparams: OP_NOP=0, OP_PUSH=1, OP_POPREP=2, OP_POP=3, OP_POP2=4, OP_SWAP=5, OP_DUP=6, OP_OVER=7;
  - a function returning the minimum required depth per opcode, reused by the control unit.
- One natural sub-module: stack_guard, a combinational block that takes stackOP and depth and produces op_ok, set_ovf and set_unf.
- Array shifting stays in the top module.

Test Plan:
- Reset, then PUSH 0x0011 then 0x0022 -> a=0x0022, b=0x0011, depth=2, empty=0.
- From [0x0022, 0x0011], DUP then OVER -> a=0x0022, b=0x0022, depth=4; then SWAP -> state unchanged (equal values); POP2 -> a=0x0022, b=0x0011, depth=2.
- DEPTH=4 instance, fill with 1,2,3,4 then PUSH 5 -> overflow=1, a=4, depth=4. Then clr_err with NOP -> overflow=0.
- Empty stack, POP -> underflow=1, depth=0, a=0. Then SWAP with depth=1 (after PUSH 7) -> underflow stays 1, a=7, b=0.
- POP_REPLACE with w=0x00AA on [3,2,1] -> a=0x00AA, b=1, depth=2, stack[2]=0. Then assert reset together with PUSH -> all zero, depth=0, flags 0.
- With STACK_PEEK_EN defined: push 1..5, peek_idx=4 -> peek_data=1; peek_idx=5 -> peek_data=0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared opcode encodings and per-opcode depth requirements for the parametrised operand stack.
package stack_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_POPREP = 3'd2;
    localparam logic [2:0] OP_POP    = 3'd3;
    localparam logic [2:0] OP_POP2   = 3'd4;
    localparam logic [2:0] OP_SWAP   = 3'd5;
    localparam logic [2:0] OP_DUP    = 3'd6;
    localparam logic [2:0] OP_OVER   = 3'd7;

    function automatic int unsigned min_depth(input logic [2:0] op);
        int unsigned req;
        req = 0;
        case (op)
            OP_POPREP: req = 2;
            OP_POP:    req = 1;
            OP_POP2:   req = 2;
            OP_SWAP:   req = 2;
            OP_DUP:    req = 1;
            OP_OVER:   req = 2;
            default:   req = 0;
        endcase
        return req;
    endfunction

    function automatic logic grows_stack(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/stack_guard.sv
// Combinational legality check: decides whether a stack op may execute and which sticky flag it raises.
module stack_guard
    import stack_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic [2:0]       stack_op,
    input  logic [CNT_W-1:0] depth,
    output logic             op_ok,
    output logic             set_ovf,
    output logic             set_unf
);

    logic need_unf;
    logic need_ovf;

    // Too few entries outranks a full stack, so DUP/OVER on an empty stack report underflow.
    always_comb begin
        need_unf = depth < CNT_W'(min_depth(stack_op));
        need_ovf = grows_stack(stack_op) && (depth == CNT_W'(DEPTH));
        set_unf  = need_unf;
        set_ovf  = need_ovf && !need_unf;
        op_ok    = !(need_unf || need_ovf);
    end

endmodule

// File: rtl/param_register_stack.sv
// Parametrised shift-register operand stack with occupancy, full/empty and sticky error flags.
// Define STACK_PEEK_EN to add the random-access peek_idx/peek_data read port.
module param_register_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [2:0]       stackOP,
    input  logic [WIDTH-1:0] w,
    input  logic             clr_err,
`ifdef STACK_PEEK_EN
    input  logic [$clog2(DEPTH)-1:0] peek_idx,
    output logic [WIDTH-1:0] peek_data,
`endif
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [CNT_W-1:0] depth,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CNT_W-1:0] depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             op_ok, set_ovf, set_unf;
    logic [WIDTH-1:0] push_val;

    stack_guard #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_guard (
        .stack_op (stackOP),
        .depth    (depth_q),
        .op_ok    (op_ok),
        .set_ovf  (set_ovf),
        .set_unf  (set_unf)
    );

    // Slots at or beyond depth are always zero, so shifting in from the end keeps them zero.
    always_comb begin
        stack_d  = stack_q;
        depth_d  = depth_q;
        push_val = w;
        if (stackOP == OP_DUP)  push_val = stack_q[0];
        if (stackOP == OP_OVER) push_val = stack_q[1];
        if (op_ok) begin
            case (stackOP)
                OP_PUSH, OP_DUP, OP_OVER: begin
                    for (int i = DEPTH - 1; i > 0; i--) stack_d[i] = stack_q[i-1];
                    stack_d[0] = push_val;
                    depth_d    = depth_q + CNT_W'(1);
                end
                OP_POPREP: begin
                    stack_d[0] = w;
                    for (int i = 1; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
                    stack_d[DEPTH-1] = '0;
                    depth_d    = depth_q - CNT_W'(1);
                end
                OP_POP: begin
                    for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
                    stack_d[DEPTH-1] = '0;
                    depth_d    = depth_q - CNT_W'(1);
                end
                OP_POP2: begin
                    for (int i = 0; i < DEPTH - 2; i++) stack_d[i] = stack_q[i+2];
                    stack_d[DEPTH-2] = '0;
                    stack_d[DEPTH-1] = '0;
                    depth_d    = depth_q - CNT_W'(2);
                end
                OP_SWAP: begin
                    stack_d[0] = stack_q[1];
                    stack_d[1] = stack_q[0];
                end
                default: ;
            endcase
        end
        ovf_d = (ovf_q && !clr_err) || set_ovf;
        unf_d = (unf_q && !clr_err) || set_unf;
    end

    always_ff @(negedge CLK) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            stack_q <= stack_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign a         = stack_q[0];
    assign b         = stack_q[1];
    assign depth     = depth_q;
    assign empty     = (depth_q == '0);
    assign full      = (depth_q == CNT_W'(DEPTH));
    assign overflow  = ovf_q;
    assign underflow = unf_q;

`ifdef STACK_PEEK_EN
    assign peek_data = stack_q[peek_idx];
`endif

endmodule
